reg_arbiter: RTL and testbench
==============================

# reg_arbiter

Round-robin arbiter and sequencer that shares one load/clear register among REQS requesters. Each requester asks to either load a data word or clear the register. The arbiter grants one requester at a time and drives the register's data, load and clear controls for exactly one cycle. It then returns the register's resulting value to the winner with a one-cycle acknowledge. It sits between requesting blocks and a single `register` instance, which it owns exclusively.

## Interface
Parameters:
- N, 8, data width of the shared register
- REQS, 4, number of requesters (2..8)

Ports:
- clk  input  1  clock; all state updates on posedge
- clear_n  input  1  asynchronous, active-low reset
- req  input  REQS  request per requester; level, held until ack
- clr_req  input  REQS  per requester: 1 = clear the register, 0 = load it
- wr_data  input  REQS*N  packed load data; requester i uses bits [i*N +: N]
- gnt  output  REQS  one-hot grant, held from grant until ack
- ack  output  REQS  one-hot, one-cycle completion pulse
- rd_data  output  N  register value after the granted operation; valid in the ack cycle and held until the next ack
- busy  output  1  high whenever state ≠ IDLE
- reg_in  output  N  to register data input
- reg_load  output  1  to register load
- reg_clear  output  1  to register clear (active high)
- reg_out  input  N  from register output

## Operation
- State machine with three states: IDLE → ISSUE → CAPTURE → IDLE. All outputs are registered.
- **IDLE**
  - Eligible requesters: req[i]=1 and ack[i]=0. An acked requester is masked for the one cycle in which its ack is high.
  - If any requester is eligible, choose winner w as the first eligible index scanning ptr, ptr+1, …, wrapping modulo REQS.
  - At the clock edge:
    - gnt ← onehot(w)
    - reg_in ← wr_data[w]
    - reg_load ← ~clr_req[w]
    - reg_clear ← clr_req[w]
    - state ← ISSUE
  - No eligible requester: remain in IDLE with all controls low.
- **ISSUE**
  - Exactly one of reg_load or reg_clear is high for this whole cycle; the register updates.
  - At the clock edge: reg_load ← 0, reg_clear ← 0, state ← CAPTURE.
- **CAPTURE**
  - At the clock edge:
    - rd_data ← reg_out
    - ack ← gnt
    - gnt ← 0
    - ptr ← (w+1) mod REQS
    - state ← IDLE
  - In IDLE, ack is cleared at the next edge.
- req, clr_req and wr_data are sampled only at the grant edge. Changes after the grant are ignored. A requester must not withdraw req before ack; if it does, the operation still completes and ack still pulses.
- reg_load and reg_clear are never high together. Neither is ever high outside ISSUE.
- Requester protocol: hold req until ack is seen. Deassert req, or change the request, in or after the ack cycle.
- Fairness: a requester that is held active is granted within REQS operations.

## Timing
- **Reset** (clear_n=0, asynchronous): the following take effect immediately and are held while clear_n=0:
  - state=IDLE, ptr=0
  - gnt=0, ack=0, rd_data=0, busy=0
  - reg_in=0, reg_load=0, reg_clear=0
- Reset does not drive reg_clear; the shared register's contents are unaffected by this block's reset.
- **Reset mid-operation:** abort immediately. No ack is issued, ptr returns to 0, and an in-flight load or clear pulse is truncated.
- Release of clear_n is synchronized by the integrating design. The first possible grant is at the first posedge after release.
- **Latency**, with req rising before edge E0 while idle:
  - gnt and reg_load/reg_clear high after E0
  - register updated at E1
  - ack and rd_data valid after E2
  - ack low after E3
- **Throughput:** one operation per 3 cycles. Back-to-back grants occur: the next grant edge is E3.

## Test plan
- **Single load.** Reset, then req=0001, clr_req=0, wr_data[0]=8'hA5.
  - Cycle 1: gnt=0001, reg_load=1, reg_in=A5.
  - Cycle 3: ack=0001, rd_data=A5.
  - busy high for cycles 1–2 only.
- **Clear.** Register holds 3C; requester 2 asserts req with clr_req=1.
  - reg_clear pulses for one cycle with reg_load=0.
  - ack=0100, rd_data=00.
- **Round-robin.** Hold req=1111 with distinct data 11/22/33/44.
  - Grants occur in order 0,1,2,3,0, spaced 3 cycles apart.
  - Each rd_data equals the granted requester's data.
- **Ack masking.** Requester 1 holds req through its ack cycle while requester 3 is idle.
  - No grant occurs in the ack cycle.
  - Requester 1 is regranted only if req is still high at the following edge.
- **Mid-operation reset.** Pull clear_n low during ISSUE.
  - All outputs go to 0 immediately; no ack is issued.
  - After release with req=1000, the grant goes to 3 via ptr=0 scanning.
- **Sampling.** Change wr_data[0] from 5A to FF one cycle after the grant.
  - rd_data=5A.
  - Withdrawing req after the grant still yields ack.

Source files
------------

// File: rtl/reg_arbiter.sv
// Round-robin arbiter owning one load/clear register: grant edge, one-cycle ISSUE, CAPTURE, then ack pulse.
// Latency: grant at E0, register written at E1, ack/rd_data at E2; requesters wait (req held) until their ack.
module reg_arbiter #(
    parameter int N    = 8,
    parameter int REQS = 4
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic [REQS-1:0]   req,
    input  logic [REQS-1:0]   clr_req,
    input  logic [REQS*N-1:0] wr_data,
    output logic [REQS-1:0]   gnt,
    output logic [REQS-1:0]   ack,
    output logic [N-1:0]      rd_data,
    output logic              busy,
    output logic [N-1:0]      reg_in,
    output logic              reg_load,
    output logic              reg_clear,
    input  logic [N-1:0]      reg_out
);

    localparam int IW = (REQS > 1) ? $clog2(REQS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [REQS-1:0] gnt_d, ack_d;
    logic [N-1:0]    rd_data_d, reg_in_d;
    logic            busy_d, reg_load_d, reg_clear_d;

    logic [REQS-1:0] elig;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;

    // A requester is masked during its own ack cycle so a held req is not instantly regranted.
    assign elig = req & ~ack;

    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < REQS; k++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(REQS)) begin
                sum = sum - (IW+1)'(REQS);
            end
            idx = sum[IW-1:0];
            if (!pick_vld && elig[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        gnt_d       = gnt;
        ack_d       = '0;
        rd_data_d   = rd_data;
        reg_in_d    = reg_in;
        reg_load_d  = 1'b0;
        reg_clear_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    win_d           = pick_idx;
                    reg_in_d        = wr_data[pick_idx*N +: N];
                    reg_load_d      = ~clr_req[pick_idx];
                    reg_clear_d     = clr_req[pick_idx];
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rd_data_d = reg_out;
                ack_d     = gnt;
                gnt_d     = '0;
                ptr_d     = (win_q == IW'(REQS-1)) ? '0 : win_q + 1'b1;
                state_d   = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Reset aborts any operation in flight; the register itself is never cleared from here.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            gnt       <= '0;
            ack       <= '0;
            rd_data   <= '0;
            busy      <= 1'b0;
            reg_in    <= '0;
            reg_load  <= 1'b0;
            reg_clear <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            gnt       <= gnt_d;
            ack       <= ack_d;
            rd_data   <= rd_data_d;
            busy      <= busy_d;
            reg_in    <= reg_in_d;
            reg_load  <= reg_load_d;
            reg_clear <= reg_clear_d;
        end
    end

    a_ctl_excl: assert property (@(posedge clk) disable iff (!clear_n)
        !(reg_load && reg_clear));
    a_ctl_issue: assert property (@(posedge clk) disable iff (!clear_n)
        (reg_load || reg_clear) |-> (state_q == ISSUE));
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!clear_n)
        $onehot0(gnt));
    a_ack_onehot: assert property (@(posedge clk) disable iff (!clear_n)
        $onehot0(ack));

endmodule

// File: tb/tb_reg_arbiter.sv
module tb_reg_arbiter;
    localparam int N    = 8;
    localparam int REQS = 4;

    logic              clk     = 1'b0;
    logic              clear_n = 1'b1;
    logic [REQS-1:0]   req     = '0;
    logic [REQS-1:0]   clr_req = '0;
    logic [REQS*N-1:0] wr_data = '0;
    logic [REQS-1:0]   gnt, ack;
    logic [N-1:0]      rd_data, reg_in, reg_out;
    logic              busy, reg_load, reg_clear;
    logic [N-1:0]      reg_q   = '0;

    reg_arbiter #(.N(N), .REQS(REQS)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .req       (req),
        .clr_req   (clr_req),
        .wr_data   (wr_data),
        .gnt       (gnt),
        .ack       (ack),
        .rd_data   (rd_data),
        .busy      (busy),
        .reg_in    (reg_in),
        .reg_load  (reg_load),
        .reg_clear (reg_clear),
        .reg_out   (reg_out)
    );

    always #5 clk = ~clk;

    // Shared register model: no reset, clear has priority.
    always @(posedge clk) begin
        if (reg_clear)     reg_q <= '0;
        else if (reg_load) reg_q <= reg_in;
    end
    assign reg_out = reg_q;

    typedef struct {
        logic [REQS-1:0] ack;
        logic [N-1:0]    rd;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [REQS-1:0]   req;
        logic [REQS-1:0]   clr;
        logic [REQS*N-1:0] wd;
        int                w;
        logic [N-1:0]      rd;
    } vec_t;
    vec_t tbl[10];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        check("ctl_exclusive", {31'd0, reg_load && reg_clear}, 32'd0);
        if (ack != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {28'd0, ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_ack", {28'd0, ack}, {28'd0, e.ack});
                check("sb_rd_data", {24'd0, rd_data}, {24'd0, e.rd});
            end
        end
    end

    // Waits (bounded) for a grant, checks the issue-cycle controls and books the expected ack.
    task automatic wait_grant(input int w, input logic clr, input logic [N-1:0] rd,
                              input int exp_wait, input string tag);
        int n = 0;
        logic [REQS-1:0] oh;
        exp_t e;
        oh = '0;
        oh[w] = 1'b1;
        do begin
            tick();
            n++;
        end while (gnt == '0 && n < 8);
        check({tag, "_wait"}, n, exp_wait);
        check({tag, "_gnt"}, {28'd0, gnt}, {28'd0, oh});
        check({tag, "_load"}, {31'd0, reg_load}, {31'd0, ~clr});
        check({tag, "_clear"}, {31'd0, reg_clear}, {31'd0, clr});
        check({tag, "_reg_in"}, {24'd0, reg_in}, {24'd0, wr_data[w*N +: N]});
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        e.ack = oh;
        e.rd  = rd;
        sb.push_back(e);
    endtask

    // Steps through ISSUE and CAPTURE; returns inside the ack cycle.
    task automatic finish_op(input int w, input string tag);
        logic [REQS-1:0] oh;
        oh = '0;
        oh[w] = 1'b1;
        tick();
        check({tag, "_cap_ctl"}, {30'd0, reg_load, reg_clear}, 32'd0);
        check({tag, "_cap_gnt"}, {28'd0, gnt}, {28'd0, oh});
        check({tag, "_cap_busy"}, {31'd0, busy}, 32'd1);
        tick();
        check({tag, "_ack"}, {28'd0, ack}, {28'd0, oh});
        check({tag, "_ack_gnt"}, {28'd0, gnt}, 32'd0);
        check({tag, "_ack_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
        check({tag, "_ack"}, {28'd0, ack}, 32'd0);
        check({tag, "_rd_data"}, {24'd0, rd_data}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_reg_in"}, {24'd0, reg_in}, 32'd0);
        check({tag, "_ctl"}, {30'd0, reg_load, reg_clear}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b1111, 4'b0000, 32'h44332211, 0, 8'h11};
        tbl[1] = '{4'b1111, 4'b0000, 32'h44332211, 1, 8'h22};
        tbl[2] = '{4'b1111, 4'b0000, 32'h44332211, 2, 8'h33};
        tbl[3] = '{4'b1111, 4'b0000, 32'h44332211, 3, 8'h44};
        tbl[4] = '{4'b1111, 4'b0000, 32'h44332211, 0, 8'h11};
        tbl[5] = '{4'b0010, 4'b0000, 32'h00003C00, 1, 8'h3C};
        tbl[6] = '{4'b0100, 4'b0100, 32'h00AA0000, 2, 8'h00};
        tbl[7] = '{4'b1001, 4'b1000, 32'h77000005, 3, 8'h00};
        tbl[8] = '{4'b1001, 4'b0000, 32'h99000005, 0, 8'h05};
        tbl[9] = '{4'b1000, 4'b0000, 32'h99000005, 3, 8'h99};

        // Reset state
        #2 clear_n = 1'b0;
        #1 check_all_zero("reset");
        tick();
        check_all_zero("reset_held");

        // Single load
        clear_n = 1'b1;
        req     = 4'b0001;
        wr_data = 32'h000000A5;
        wait_grant(0, 1'b0, 8'hA5, 1, "single");
        finish_op(0, "single");
        req = '0;
        tick();
        check("single_ack_low", {28'd0, ack}, 32'd0);
        check("single_idle_busy", {31'd0, busy}, 32'd0);

        // Fresh reset, then round-robin / clear / mixed table
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req     = tbl[i].req;
            clr_req = tbl[i].clr;
            wr_data = tbl[i].wd;
            wait_grant(tbl[i].w, tbl[i].clr[tbl[i].w], tbl[i].rd, 1, $sformatf("vec%0d", i));
            finish_op(tbl[i].w, $sformatf("vec%0d", i));
        end

        // Ack masking: requester 1 holds req through its ack cycle
        req     = 4'b0010;
        clr_req = '0;
        wr_data = 32'h0000C300;
        wait_grant(1, 1'b0, 8'hC3, 1, "mask1");
        finish_op(1, "mask1");
        wr_data = 32'h00006B00;
        tick();
        check("mask_no_gnt", {28'd0, gnt}, 32'd0);
        check("mask_no_busy", {31'd0, busy}, 32'd0);
        wait_grant(1, 1'b0, 8'h6B, 1, "mask2");
        finish_op(1, "mask2");
        req = '0;
        tick();

        // Sampling: data and req changes after the grant are ignored
        req     = 4'b0001;
        wr_data = 32'h0000005A;
        wait_grant(0, 1'b0, 8'h5A, 1, "sample");
        wr_data = 32'h000000FF;
        req     = '0;
        finish_op(0, "sample");
        tick();
        check("sample_no_regrant", {28'd0, gnt}, 32'd0);

        // Reset during ISSUE aborts the operation
        req     = 4'b1000;
        wr_data = 32'hE7000012;
        tick();
        check("pre_rst_gnt", {28'd0, gnt}, 32'h8);
        check("pre_rst_load", {31'd0, reg_load}, 32'd1);
        #2 clear_n = 1'b0;
        #1 check_all_zero("midrst");
        tick();
        tick();
        check("midrst_reg_kept", {24'd0, reg_q}, 32'h5A);
        req     = 4'b1001;
        clear_n = 1'b1;
        wait_grant(0, 1'b0, 8'h12, 1, "post_rst0");
        finish_op(0, "post_rst0");
        req = 4'b1000;
        wait_grant(3, 1'b0, 8'hE7, 1, "post_rst3");
        finish_op(3, "post_rst3");
        req = '0;
        tick();
        tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
